// File: rtl/sound_arbiter.sv
// sound_arbiter: latches request edges and plays one fixed-priority sound at a time, each followed by a silence gap
module sound_arbiter #(
   parameter int NUM_REQ     = 6,
   parameter int PLAY_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 2_500_000,
   parameter bit PREEMPT     = 1'b0,
   parameter int CNT_W       = 32,
   parameter int IDX_W       = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic [NUM_REQ-1:0] reqIn,
   input  logic               mute,
   output logic               soundActive,
   output logic [IDX_W-1:0]   soundIdx,
   output logic [NUM_REQ-1:0] soundOneHot,
   output logic               startPulse,
   output logic [NUM_REQ-1:0] pendingOut
);
   typedef enum logic [1:0] {IDLE, PLAY, GAP} stateT;
   stateT state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [NUM_REQ-1:0] reqPrev, pending, pendingNext, rise, clearMask;
   logic [IDX_W-1:0] winIdx, idxNext;
   logic hasPend, grant, preempt;
   assign rise = reqIn & ~reqPrev;
   assign hasPend = |pending;
   assign pendingOut = pending;
   assign preempt = PREEMPT && state == PLAY && hasPend && winIdx < soundIdx;
   // the lowest set pending index wins
   always_comb begin
      winIdx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (pending[i]) winIdx = IDX_W'(i);
   end
   // next state, duration counter and grant decision; mute overrides everything
   always_comb begin
      stateNext = state;
      cntNext = cnt;
      grant = 1'b0;
      case (state)
         IDLE: begin
            stateNext = hasPend ? PLAY : IDLE;
            grant = hasPend;
         end
         PLAY: begin
            grant = preempt;
            stateNext = (!preempt && cnt == '0) ? GAP : PLAY;
            cntNext = preempt ? cnt : (cnt == '0) ? CNT_W'(GAP_CYCLES - 1) : cnt - CNT_W'(1);
         end
         default: begin
            stateNext = (cnt == '0) ? IDLE : GAP;
            cntNext = (cnt == '0) ? cnt : cnt - CNT_W'(1);
         end
      endcase
      if (grant) cntNext = CNT_W'(PLAY_CYCLES - 1);
      if (mute) begin
         stateNext = IDLE;
         cntNext = '0;
         grant = 1'b0;
      end
   end
   // a granted channel clears its pending bit, but a rise in the same cycle sets it again
   assign clearMask = grant ? NUM_REQ'(1) << winIdx : '0;
   assign pendingNext = mute ? '0 : (pending & ~clearMask) | rise;
   assign idxNext = (stateNext == PLAY) ? (grant ? winIdx : soundIdx) : '0;
   // state, counter, edge history, pending set and registered outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= IDLE;
         cnt <= '0;
         reqPrev <= '0;
         pending <= '0;
         soundIdx <= '0;
         soundActive <= 1'b0;
         soundOneHot <= '0;
         startPulse <= 1'b0;
      end else begin
         state <= stateNext;
         cnt <= cntNext;
         reqPrev <= reqIn;
         pending <= pendingNext;
         soundIdx <= idxNext;
         soundActive <= stateNext == PLAY;
         soundOneHot <= (stateNext == PLAY) ? NUM_REQ'(1) << idxNext : '0;
         startPulse <= grant;
      end
   end
endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: checks a non-preempting and a preempting arbiter against a cycle-level behavioural model
module tb_sound_arbiter;
   localparam int N = 6, PLAY = 8, GAP = 2;
   logic clk = 1'b0, resetN = 1'b0, mute = 1'b0;
   logic [N-1:0] reqIn = '0;
   logic [1:0] act, st;
   logic [2:0] idx0, idx1;
   logic [N-1:0] oh0, oh1, pd0, pd1;
   int tests = 0, fails = 0, cyc = 0;
   bit chkEn = 1'b0;
   int pRem[2], gRem[2], cur[2];
   logic [N-1:0] pend[2], prv[2];
   bit mSt[2];

   sound_arbiter #(.NUM_REQ(N), .PLAY_CYCLES(PLAY), .GAP_CYCLES(GAP), .PREEMPT(1'b0), .CNT_W(8)) dut0 (
      .clk(clk), .resetN(resetN), .reqIn(reqIn), .mute(mute), .soundActive(act[0]), .soundIdx(idx0),
      .soundOneHot(oh0), .startPulse(st[0]), .pendingOut(pd0));
   sound_arbiter #(.NUM_REQ(N), .PLAY_CYCLES(PLAY), .GAP_CYCLES(GAP), .PREEMPT(1'b1), .CNT_W(8)) dut1 (
      .clk(clk), .resetN(resetN), .reqIn(reqIn), .mute(mute), .soundActive(act[1]), .soundIdx(idx1),
      .soundOneHot(oh1), .startPulse(st[1]), .pendingOut(pd1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int gAct(int m); return m ? int'(act[1]) : int'(act[0]); endfunction
   function automatic int gSt(int m); return m ? int'(st[1]) : int'(st[0]); endfunction
   function automatic int gIdx(int m); return m ? int'(idx1) : int'(idx0); endfunction
   function automatic int gOh(int m); return m ? int'(oh1) : int'(oh0); endfunction
   function automatic int gPd(int m); return m ? int'(pd1) : int'(pd0); endfunction

   task automatic chk(input string name, input int m, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, m, got, exp, cyc);
      end
   endtask

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic grantM(input int m, input int lo);
      cur[m] = lo;
      pend[m][lo] = 1'b0;
      pRem[m] = PLAY;
      mSt[m] = 1'b1;
   endtask

   task automatic mReset();
      for (int m = 0; m < 2; m++) begin
         pRem[m] = 0; gRem[m] = 0; cur[m] = 0; pend[m] = '0; prv[m] = '0; mSt[m] = 1'b0;
      end
   endtask

   // model: play remaining / gap remaining counts; zero both means idle
   task automatic modelStep(input int m, input bit pre);
      logic [N-1:0] rise;
      int lo;
      rise = reqIn & ~prv[m];
      prv[m] = reqIn;
      mSt[m] = 1'b0;
      lo = lowest(pend[m]);
      if (mute) begin
         pend[m] = '0; pRem[m] = 0; gRem[m] = 0;
      end else begin
         if (pRem[m] > 0) begin
            if (pre && lo >= 0 && lo < cur[m]) grantM(m, lo);
            else begin
               pRem[m]--;
               if (pRem[m] == 0) gRem[m] = GAP;
            end
         end else if (gRem[m] > 0) gRem[m]--;
         else if (lo >= 0) grantM(m, lo);
         pend[m] = pend[m] | rise;
      end
   endtask

   initial begin
      mReset();
      forever begin
         @(posedge clk or negedge resetN);
         if (!resetN) mReset();
         else begin
            modelStep(0, 1'b0);
            modelStep(1, 1'b1);
         end
      end
   end

   task automatic cmpModel(input int m);
      int ea;
      ea = (pRem[m] > 0) ? 1 : 0;
      chk("active", m, gAct(m), ea);
      chk("idx", m, gIdx(m), ea ? cur[m] : 0);
      chk("onehot", m, gOh(m), ea ? (1 << cur[m]) : 0);
      chk("start", m, gSt(m), int'(mSt[m]));
      chk("pending", m, gPd(m), int'(pend[m]));
   endtask

   initial forever begin
      @(negedge clk);
      if (resetN && chkEn) begin
         cmpModel(0);
         cmpModel(1);
      end
   end

   task automatic pulse(input logic [N-1:0] v);
      reqIn = v;
      @(negedge clk);
      reqIn = '0;
   endtask

   task automatic settle();
      reqIn = '0;
      mute = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   task automatic waitStart(input int m, input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         if (gSt(m) == 1) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
      if (at < 0) chk("start_timeout", m, 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks", tests);
      $fatal(1);
   end

   initial begin
      int at, c0, n, s0, s1, bad;
      int sIdx[$];
      int sCyc[$];
      logic [N-1:0] pdAt;
      // reset: outputs zero, level held through release counts once
      reqIn = 6'b100000;
      repeat (2) @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("rst_active", m, gAct(m), 0);
         chk("rst_pending", m, gPd(m), 0);
         chk("rst_onehot", m, gOh(m), 0);
      end
      resetN = 1'b1;
      chkEn = 1'b1;
      waitStart(0, 6, at);
      chk("rst_level_idx", 0, gIdx(0), 5);
      n = 0;
      for (int i = 0; i < 30; i++) begin @(negedge clk); n += gSt(0); end
      chk("rst_level_once", 0, n, 0);
      settle();

      // single pulse on channel 3
      pulse(6'b001000);
      for (int m = 0; m < 2; m++) begin
         chk("sp_pending", m, gPd(m), 6'b001000);
         chk("sp_not_yet", m, gAct(m), 0);
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("sp_start", m, gSt(m), 1);
         chk("sp_idx", m, gIdx(m), 3);
         chk("sp_onehot", m, gOh(m), 6'b001000);
      end
      n = 0; s0 = 0;
      for (int i = 0; i < 12; i++) begin n += gAct(0); s0 += gSt(0); @(negedge clk); end
      chk("sp_play_len", 0, n, PLAY);
      chk("sp_start_cnt", 0, s0, 1);
      chk("sp_idle_after", 0, gAct(0), 0);
      settle();

      // simultaneous requests play in index order, one slot apart
      pulse(6'b100101);
      for (int i = 0; i < 40; i++) begin
         if (gSt(0) == 1) begin
            sIdx.push_back(gIdx(0));
            sCyc.push_back(cyc);
            pdAt = pd0;
         end
         @(negedge clk);
      end
      chk("sim_count", 0, sIdx.size(), 3);
      if (sIdx.size() == 3) begin
         chk("sim_first", 0, sIdx[0], 0);
         chk("sim_second", 0, sIdx[1], 2);
         chk("sim_third", 0, sIdx[2], 5);
         chk("sim_spacing1", 0, sCyc[1] - sCyc[0], PLAY + GAP + 1);
         chk("sim_spacing2", 0, sCyc[2] - sCyc[1], PLAY + GAP + 1);
         chk("sim_pending_empty", 0, int'(pdAt), 0);
      end
      settle();

      // held level fires once; re-assert fires again
      reqIn = 6'b000010;
      s0 = 0; s1 = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); s0 += gSt(0); s1 += gSt(1); end
      reqIn = '0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); s0 += gSt(0); s1 += gSt(1); end
      chk("held_once", 0, s0, 1);
      chk("held_once", 1, s1, 1);
      pulse(6'b000010);
      s0 = 0;
      for (int i = 0; i < 20; i++) begin s0 += gSt(0); @(negedge clk); end
      chk("held_rearm", 0, s0, 1);
      settle();

      // preemption: idx 4 playing, idx 1 arrives on the third play cycle
      pulse(6'b010000);
      @(negedge clk);
      chk("pre_first_idx", 1, gIdx(1), 4);
      c0 = cyc;
      repeat (2) @(negedge clk);
      pulse(6'b000010);
      @(negedge clk);
      chk("pre_start", 1, gSt(1), 1);
      chk("pre_idx", 1, gIdx(1), 1);
      chk("pre_onehot", 1, gOh(1), 6'b000010);
      chk("nopre_idx", 0, gIdx(0), 4);
      chk("nopre_pending", 0, gPd(0), 6'b000010);
      n = 0; bad = 0; at = -1;
      for (int i = 0; i < 20; i++) begin
         n += gAct(1);
         if (gSt(1) == 1 && gIdx(1) == 4) bad++;
         if (gSt(0) == 1 && at < 0) begin at = cyc; s0 = gIdx(0); end
         @(negedge clk);
      end
      chk("pre_full_play", 1, n, PLAY);
      chk("pre_no_replay", 1, bad, 0);
      chk("nopre_after_gap", 0, at - c0, PLAY + GAP + 1);
      chk("nopre_second_idx", 0, s0, 1);
      settle();

      // mute mid-play flushes pending and swallows requests made during mute
      pulse(6'b000001);
      @(negedge clk);
      pulse(6'b000110);
      chk("mute_pending_pre", 0, gPd(0), 6'b000110);
      mute = 1'b1;
      reqIn = 6'b001000;
      @(negedge clk);
      mute = 1'b0;
      for (int m = 0; m < 2; m++) begin
         chk("mute_active", m, gAct(m), 0);
         chk("mute_pending", m, gPd(m), 0);
      end
      s0 = 0;
      for (int i = 0; i < 15; i++) begin @(negedge clk); s0 += gSt(0) + gSt(1); end
      chk("mute_no_fire", 0, s0, 0);
      settle();

      // async reset mid-gap with a request pending
      pulse(6'b000001);
      @(negedge clk);
      pulse(6'b000100);
      for (int i = 0; i < 20 && gAct(0) == 1; i++) @(negedge clk);
      chk("gap_reached", 0, gAct(0), 0);
      chk("gap_pending", 0, gPd(0), 6'b000100);
      #2 resetN = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("arst_active", m, gAct(m), 0);
         chk("arst_pending", m, gPd(m), 0);
         chk("arst_idx", m, gIdx(m), 0);
         chk("arst_start", m, gSt(m), 0);
      end
      @(negedge clk);
      resetN = 1'b1;
      pulse(6'b001000);
      waitStart(0, 4, at);
      chk("arst_restart_idx", 0, gIdx(0), 3);
      s0 = 0;
      for (int i = 0; i < 30; i++) begin @(negedge clk); s0 += gSt(0); end
      chk("arst_no_old", 0, s0, 0);
      settle();

      // re-request of the playing channel replays after the gap
      pulse(6'b000100);
      @(negedge clk);
      chk("rr_idx", 0, gIdx(0), 2);
      c0 = cyc;
      repeat (2) @(negedge clk);
      pulse(6'b000100);
      for (int m = 0; m < 2; m++) chk("rr_pending", m, gPd(m), 6'b000100);
      waitStart(0, 20, at);
      chk("rr_replay_time", 0, at - c0, PLAY + GAP + 1);
      chk("rr_replay_idx", 0, gIdx(0), 2);
      settle();

      // randomized traffic with occasional mute, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 4) == 0) reqIn = N'($urandom) & N'($urandom);
         mute = ($urandom_range(0, 149) == 0);
      end
      settle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Parametrised successor to the combinational sound request mux. It takes NUM_REQ one-cycle or level event inputs from key handling and collision detection and latches each rising edge as a pending request. A fixed-priority arbiter then plays exactly one sound at a time for a programmable duration, followed by a silence gap. An optional preemption mode lets a higher-priority event cut the current sound short. It sits between the game logic and the tone/sample generator, which consumes a one-hot select and a start strobe.

## Interface
- NUM_REQ, 6: number of request channels (2..32). Index 0 is the highest priority.
- PLAY_CYCLES, 25_000_000: clocks each sound is active (≥1).
- GAP_CYCLES, 2_500_000: silent clocks after each sound (≥1).
- PREEMPT, 0: 1 means a higher-priority pending request interrupts the current sound.
- CNT_W, 32: width of the duration counter. Must hold max(PLAY_CYCLES, GAP_CYCLES)-1.
- IDX_W, $clog2(NUM_REQ): width of soundIdx.
- clk  in  1  system clock. One clock domain.
- resetN  in  1  asynchronous, active-low reset.
- reqIn  in  NUM_REQ  event inputs, pulse or level. Only rising edges count.
- mute  in  1  synchronous silence/flush.
- soundActive  out  1  high while a sound plays.
- soundIdx  out  IDX_W  index of the playing channel. 0 when idle.
- soundOneHot  out  NUM_REQ  one-hot of soundIdx while playing. All-zero otherwise.
- startPulse  out  1  one-cycle strobe on the first cycle of every sound, including preemptions.
- pendingOut  out  NUM_REQ  current pending vector, for debug.

## Operation
- Edge detect: reqPrev is registered from reqIn. A rise is reqIn & ~reqPrev. A level held high fires once.
- Pending: on a rise, pending[i] sets. It clears when channel i is granted. If a set and a clear hit the same channel in the same cycle, the set wins, so the channel replays later.
- Arbiter: the lowest set index of pending wins.
- States are IDLE, PLAY and GAP.
  - IDLE to PLAY when pending≠0. The winner is registered into soundIdx, its pending bit clears, the counter loads PLAY_CYCLES-1, and startPulse is asserted.
  - PLAY: the counter decrements. At 0 go to GAP and load the counter with GAP_CYCLES-1.
  - PLAY with PREEMPT=1: if a pending index is lower than soundIdx, stay in PLAY with the new winner. Reload the counter, clear the new winner's pending bit, and assert startPulse. The preempted sound is dropped, not re-queued. Equal or lower-priority pending requests never preempt.
  - GAP: the counter decrements. At 0 go to IDLE. Pending requests are still captured during GAP.
- mute=1: next state is IDLE, pending clears, and rises are ignored. reqPrev still tracks reqIn, so requests made during mute do not fire on unmute.
- Outputs are registered. soundActive=(state==PLAY) and soundOneHot=active ? 1<<soundIdx : 0.

## Timing
- Reset (async assert, sync to clk on release): state=IDLE, counter=0, pending=0, reqPrev=0, all outputs 0. A reqIn held high through reset release counts as one rise on the first clock.
- Latency: rise sampled at edge k sets pending at edge k. From IDLE, PLAY and startPulse are visible after edge k+1, i.e. 2 clocks from reqIn rising to soundActive.
- soundActive stays high for exactly PLAY_CYCLES clocks. It is then low for exactly GAP_CYCLES clocks plus 1 IDLE clock before the next pending sound starts. Back-to-back sound starts are therefore PLAY_CYCLES+GAP_CYCLES+1 apart.
- Multiple simultaneous rises set all their bits. They are played in index order, one per slot.
- A preemption takes effect 1 clock after the higher-priority pending bit sets. The new sound gets a full PLAY_CYCLES.
- Reset mid-PLAY aborts immediately: outputs go to 0 asynchronously.

## Test plan
Bench parameters: NUM_REQ=6, PLAY_CYCLES=8, GAP_CYCLES=2.
- Single pulse: reqIn[3] pulses for 1 clk at cycle 10. Required: soundActive high cycles 12–19, soundIdx=3, soundOneHot=6'b001000, startPulse only at 12, idle again from 20.
- Simultaneous requests: reqIn=6'b100101 in one clk. Required: plays idx 0, then 2, then 5. startPulses are 11 clocks apart. pendingOut empties after the third start.
- Held level: reqIn[1] held high for 40 clk. Required: exactly one sound. A second rise after release and re-assert gives a second sound.
- Preemption: PREEMPT=1, idx 4 playing, reqIn[1] pulses on the 3rd PLAY cycle. Required: startPulse with soundIdx=1 2 clocks later, full 8-cycle play, idx 4 not replayed. With PREEMPT=0, idx 1 plays after idx 4's gap instead.
- Mute/reset: mute pulses mid-PLAY with pending=6'b000110. Required: soundActive 0 next clk and pendingOut=0. In a separate run, resetN is asserted low mid-GAP: outputs are 0 with no clk edge, and the block restarts from IDLE.
- Re-request of the playing channel: reqIn[2] rises during its own PLAY. Required: pending[2]=1 and idx 2 replays after the gap.
